bundler_sched_hf: RTL and testbench

Sequencing controller for the `bundler_hf` majority bundler. It accepts hypervectors one per handshake from an upstream stream and assembles them into the NUM_HVS-entry array the bundler consumes. It then fires the bundler with a single-cycle enable, waits for its `out` pulse with a watchdog, and presents the bundled result downstream under a valid/ready handshake. It sits between the spatial/temporal encoder stream and the classifier stage of the HDC seizure-detection pipeline.

---
 rtl/bundler_sched_hf.sv | 144 ++++++++++++++
 tb/tb_bundler_sched_hf.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bundler_sched_hf.sv
// Sequencing controller for the bundler_hf majority bundler: collects NUM_HVS hypervectors,
// fires the bundler, waits for its result under a watchdog and hands it downstream.
module bundler_sched_hf #(
    parameter int unsigned DIMENSIONS = 5,
    parameter int unsigned NUM_HVS    = 5,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [DIMENSIONS-1:0]               hv_in,
    input  logic                                hv_in_valid,
    output logic                                hv_in_ready,
    output logic                                bun_en,
    output logic [NUM_HVS-1:0][DIMENSIONS-1:0]  bun_hv_array,
    input  logic                                bun_out,
    input  logic [DIMENSIONS-1:0]               bun_hv_out,
    output logic [DIMENSIONS-1:0]               hv_out,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                busy,
    output logic                                timeout_err,
    output logic [CNT_W-1:0]                    bundle_cnt
);

    localparam int unsigned IDX_W = (NUM_HVS > 1) ? $clog2(NUM_HVS) : 1;
    localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StFill, StFire, StWait, StHold} state_e;

    state_e                             state_q, state_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic [WD_W-1:0]                    wdog_q, wdog_d;
    logic [NUM_HVS-1:0][DIMENSIONS-1:0] slots_q;
    logic [DIMENSIONS-1:0]              hv_out_q, hv_out_d;
    logic                               out_valid_q, out_valid_d;
    logic                               timeout_q, timeout_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic                               slot_we;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wdog_d      = wdog_q;
        hv_out_d    = hv_out_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;
        slot_we     = 1'b0;
        hv_in_ready = 1'b0;
        bun_en      = 1'b0;
        busy        = 1'b0;

        unique case (state_q)
            StFill: begin
                hv_in_ready = 1'b1;
                if (hv_in_valid) begin
                    slot_we = 1'b1;
                    if (idx_q == IDX_W'(NUM_HVS - 1)) begin
                        idx_d   = '0;
                        state_d = StFire;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            StFire: begin
                bun_en  = 1'b1;
                busy    = 1'b1;
                wdog_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                busy = 1'b1;
                // A result arriving on the expiry cycle still counts as success.
                if (bun_out) begin
                    hv_out_d    = bun_hv_out;
                    out_valid_d = 1'b1;
                    state_d     = StHold;
                end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    idx_d     = '0;
                    state_d   = StFill;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            StHold: begin
                busy = 1'b1;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_d       = cnt_q + CNT_W'(1);
                    state_d     = StFill;
                end
            end
            default: state_d = StFill;
        endcase

        // Abort keeps slot contents, hv_out and the bundle count.
        if (flush) begin
            state_d     = StFill;
            idx_d       = '0;
            wdog_d      = '0;
            out_valid_d = 1'b0;
            hv_out_d    = hv_out_q;
            cnt_d       = cnt_q;
            timeout_d   = 1'b0;
            slot_we     = 1'b0;
            bun_en      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StFill;
            idx_q       <= '0;
            wdog_q      <= '0;
            slots_q     <= '0;
            hv_out_q    <= '0;
            out_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wdog_q      <= wdog_d;
            hv_out_q    <= hv_out_d;
            out_valid_q <= out_valid_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
            if (slot_we) begin
                slots_q[idx_q] <= hv_in;
            end
        end
    end

    assign bun_hv_array = slots_q;
    assign hv_out       = hv_out_q;
    assign out_valid    = out_valid_q;
    assign timeout_err  = timeout_q;
    assign bundle_cnt   = cnt_q;

endmodule

// File: tb/tb_bundler_sched_hf.sv
// Bench for bundler_sched_hf: transaction-level reference model compared every cycle, a
// majority-vote bundler stand-in, and directed scenarios with hand-computed results.
module tb_bundler_sched_hf;

    localparam int D  = 5;
    localparam int N  = 5;
    localparam int TO = 16;
    localparam int CW = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush;
    logic [D-1:0]          hv_in;
    logic                  hv_in_valid;
    logic                  hv_in_ready;
    logic                  bun_en;
    logic [N-1:0][D-1:0]   bun_hv_array;
    logic                  bun_out = 1'b0;
    logic [D-1:0]          bun_hv_out = '0;
    logic [D-1:0]          hv_out;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  timeout_err;
    logic [CW-1:0]         bundle_cnt;

    bundler_sched_hf #(
        .DIMENSIONS(D), .NUM_HVS(N), .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .hv_in(hv_in), .hv_in_valid(hv_in_valid), .hv_in_ready(hv_in_ready),
        .bun_en(bun_en), .bun_hv_array(bun_hv_array),
        .bun_out(bun_out), .bun_hv_out(bun_hv_out),
        .hv_out(hv_out), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .timeout_err(timeout_err), .bundle_cnt(bundle_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int en_cnt = 0;
    int t_fire = -1;
    int t_terr = -1;
    bit chk_on = 1'b0;
    int lat    = 1;
    bit resp   = 1'b1;

    logic [D-1:0] set1 [N] = '{5'b01101, 5'b00111, 5'b01111, 5'b00011, 5'b00011};
    logic [D-1:0] set2 [N] = '{5'b00010, 5'b10000, 5'b01000, 5'b10100, 5'b00100};
    logic [D-1:0] set3 [N] = '{5'b11011, 5'b11011, 5'b01111, 5'b10111, 5'b10101};
    logic [D-1:0] setp [3] = '{5'b10101, 5'b01010, 5'b11100};
    logic [D-1:0] set5 [N] = '{5'b11000, 5'b11000, 5'b00111, 5'b10001, 5'b01010};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [D-1:0] majority(input logic [N-1:0][D-1:0] a);
        logic [D-1:0] r;
        for (int b = 0; b < D; b++) begin
            int ones;
            ones = 0;
            for (int k = 0; k < N; k++) ones += int'(a[k][b]);
            r[b] = (ones > N / 2);
        end
        return r;
    endfunction

    // Bundler stand-in: answers L cycles after bun_en with the bitwise majority.
    int           pend_cnt = 0;
    logic [D-1:0] pend_val = '0;
    always @(negedge clk) begin
        bun_out <= 1'b0;
        if (pend_cnt > 0) begin
            if (pend_cnt == 1) begin
                bun_out    <= 1'b1;
                bun_hv_out <= pend_val;
            end
            pend_cnt--;
        end
        if (bun_en === 1'b1 && resp) begin
            pend_cnt = lat;
            pend_val = majority(bun_hv_array);
        end
    end

    // Reference model, advanced once per rising edge from the sampled inputs.
    typedef enum {MFill, MFire, MWait, MHold} mphase_e;
    mphase_e             m_ph;
    int                  m_fill;
    int                  m_wait;
    logic [N-1:0][D-1:0] m_slots;
    logic [D-1:0]        m_hv_out;
    logic                m_valid;
    logic                m_terr;
    logic [CW-1:0]       m_cnt;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_ph = MFill; m_fill = 0; m_wait = 0; m_slots = '0;
            m_hv_out = '0; m_valid = 1'b0; m_terr = 1'b0; m_cnt = '0;
        end else if (flush) begin
            m_ph = MFill; m_fill = 0; m_wait = 0; m_valid = 1'b0; m_terr = 1'b0;
        end else begin
            m_terr = 1'b0;
            case (m_ph)
                MFill: if (hv_in_valid) begin
                    m_slots[m_fill] = hv_in;
                    m_fill++;
                    if (m_fill == N) begin
                        m_fill = 0;
                        m_ph   = MFire;
                    end
                end
                MFire: begin
                    m_wait = 0;
                    m_ph   = MWait;
                end
                MWait: if (bun_out) begin
                    m_hv_out = bun_hv_out;
                    m_valid  = 1'b1;
                    m_ph     = MHold;
                end else begin
                    m_wait++;
                    if (m_wait == TO) begin
                        m_terr = 1'b1;
                        m_fill = 0;
                        m_ph   = MFill;
                    end
                end
                MHold: if (out_ready) begin
                    m_valid = 1'b0;
                    m_cnt   = m_cnt + 1'b1;
                    m_ph    = MFill;
                end
                default: m_ph = MFill;
            endcase
        end
    end

    always @(negedge clk) begin
        if (bun_en === 1'b1) begin
            en_cnt++;
            t_fire = cyc;
        end
        if (timeout_err === 1'b1) t_terr = cyc;
        if (chk_on) begin
            chk("hv_in_ready", 64'(hv_in_ready), 64'(m_ph == MFill));
            chk("bun_en", 64'(bun_en), 64'(m_ph == MFire && !flush));
            chk("busy", 64'(busy), 64'(m_ph != MFill));
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            chk("hv_out", 64'(hv_out), 64'(m_hv_out));
            chk("timeout_err", 64'(timeout_err), 64'(m_terr));
            chk("bundle_cnt", 64'(bundle_cnt), 64'(m_cnt));
            chk("bun_hv_array", 64'(bun_hv_array), 64'(m_slots));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [D-1:0] v);
        bit ok;
        ok          = 1'b0;
        hv_in       = v;
        hv_in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            logic r;
            r = hv_in_ready;
            tick();
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        chk("send_accept", 64'(ok), 64'(1));
    endtask

    task automatic send_set(input logic [D-1:0] s [N], input bit gap);
        for (int i = 0; i < N; i++) begin
            send(s[i]);
            if (gap) begin
                hv_in_valid = 1'b0;
                tick();
            end
        end
        hv_in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 100 && out_valid !== 1'b1; i++) tick();
        chk(name, 64'(out_valid), 64'(1));
    endtask

    task automatic wait_cnt(input string name, input int target);
        for (int i = 0; i < 100 && bundle_cnt !== CW'(target); i++) tick();
        chk(name, 64'(bundle_cnt), 64'(target));
    endtask

    int e0;

    initial begin
        rst = 1'b1; flush = 1'b0; hv_in = '0; hv_in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk_on = 1'b1;
        tick();
        rst = 1'b0;
        chk("reset_ready", 64'(hv_in_ready), 64'(1));
        chk("reset_hv_out", 64'(hv_out), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_cnt", 64'(bundle_cnt), 64'(0));

        // Fill and bundle, valid held high.
        e0 = en_cnt;
        send_set(set1, 1'b0);
        wait_cnt("t1_cnt", 1);
        chk("t1_hv_out", 64'(hv_out), 64'(5'b00111));
        chk("t1_en_pulses", 64'(en_cnt - e0), 64'(1));

        // Backpressure.
        out_ready = 1'b0;
        send_set(set2, 1'b0);
        wait_valid("t2_valid");
        repeat (5) begin
            tick();
            chk("t2_hold_hv", 64'(hv_out), 64'(5'b00000));
            chk("t2_hold_ready", 64'(hv_in_ready), 64'(0));
        end
        out_ready = 1'b1;
        wait_cnt("t2_cnt", 2);
        chk("t2_ready_after", 64'(hv_in_ready), 64'(1));

        // Gapped input.
        e0 = en_cnt;
        send_set(set3, 1'b1);
        wait_cnt("t3_cnt", 3);
        chk("t3_hv_out", 64'(hv_out), 64'(5'b11111));
        chk("t3_en_pulses", 64'(en_cnt - e0), 64'(1));

        // Watchdog.
        resp = 1'b0; t_fire = -1; t_terr = -1;
        send_set(set1, 1'b0);
        for (int i = 0; i < 100 && t_terr < 0; i++) tick();
        chk("t4_terr_delay", 64'(t_terr - (t_fire + 1)), 64'(TO));
        tick();
        chk("t4_valid", 64'(out_valid), 64'(0));
        chk("t4_cnt", 64'(bundle_cnt), 64'(3));
        chk("t4_ready", 64'(hv_in_ready), 64'(1));
        resp = 1'b1;

        // Flush mid-fill, then flush in HOLD.
        out_ready = 1'b0;
        e0 = en_cnt;
        for (int i = 0; i < 3; i++) send(setp[i]);
        hv_in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (3) tick();
        chk("t5_no_fire", 64'(en_cnt - e0), 64'(0));
        send_set(set5, 1'b0);
        wait_valid("t5_valid");
        chk("t5_en_pulses", 64'(en_cnt - e0), 64'(1));
        chk("t5_hv_out", 64'(hv_out), 64'(5'b11000));
        repeat (2) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_flush_valid", 64'(out_valid), 64'(0));
        chk("t5_flush_cnt", 64'(bundle_cnt), 64'(3));
        chk("t5_flush_hv", 64'(hv_out), 64'(5'b11000));
        out_ready = 1'b1;

        // Reset while waiting; the late bun_out must be ignored.
        lat = 4;
        send_set(set2, 1'b0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_ready", 64'(hv_in_ready), 64'(1));
        chk("t6_hv_out", 64'(hv_out), 64'(0));
        chk("t6_cnt", 64'(bundle_cnt), 64'(0));
        chk("t6_array", 64'(bun_hv_array), 64'(0));
        chk("t6_busy", 64'(busy), 64'(0));
        repeat (6) begin
            tick();
            chk("t6_ignored", 64'(out_valid), 64'(0));
        end

        lat = 1;
        send_set(set3, 1'b0);
        wait_cnt("t7_cnt", 1);
        chk("t7_hv_out", 64'(hv_out), 64'(5'b11111));
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
